// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO: start bit, DATA_BITS LSB first, optional parity (UART_TX_PARITY_EN), STOP_BITS.
// The first start bit drives two edges after the write; writes while full are dropped and pulse overflow; pause freezes only the serialiser.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          pause,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_next;
  logic                 push;
  logic                 pop;

  // push looks at the registered full, so a same-edge pop never makes room for it
  assign push = wr_en & ~full;

  always_comb begin
    count_next = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_next;
      full       <= (count_next == CW'(FIFO_DEPTH));
      empty      <= (count_next == '0);
      overflow   <= wr_en & full;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 tx_n;
  logic                 bit_end;
  logic                 load;
`ifdef UART_TX_PARITY_EN
  logic                 par_odd_q, par_odd_n;
`endif

  assign bit_end = (timer == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    tx_n      = tx;
    pop       = 1'b0;
    load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_odd_n = par_odd_q;
`endif
    if (!pause) begin
      if (state == S_IDLE) begin
        tx_n = 1'b1;
        load = ~empty;
      end else if (!bit_end) begin
        timer_n = timer + TW'(1);
      end else begin
        timer_n = '0;
        case (state)
          S_START: begin
            state_n   = S_DATA;
            bit_idx_n = '0;
            tx_n      = shift_reg[0];
          end
          S_DATA: begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_n = S_PARITY;
              tx_n    = (^shift_reg) ^ par_odd_q;
`else
              state_n   = S_STOP;
              bit_idx_n = '0;
              tx_n      = 1'b1;
`endif
            end else begin
              bit_idx_n = bit_idx + IW'(1);
              tx_n      = shift_reg[bit_idx_n];
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state_n   = S_STOP;
            bit_idx_n = '0;
            tx_n      = 1'b1;
          end
`endif
          S_STOP: begin
            if (bit_idx == IW'(STOP_BITS - 1)) begin
              // chain straight into the next start bit when data is waiting
              if (!empty) begin
                load = 1'b1;
              end else begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
              end
            end else begin
              bit_idx_n = bit_idx + IW'(1);
            end
          end
          default: begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        endcase
      end
      if (load) begin
        pop       = 1'b1;
        shift_n   = mem[rd_ptr];
        state_n   = S_START;
        timer_n   = '0;
        bit_idx_n = '0;
        tx_n      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_odd_n = parity_odd;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      tx        <= tx_n;
      tx_busy   <= (state != S_IDLE) | ~empty;
`ifdef UART_TX_PARITY_EN
      par_odd_q <= par_odd_n;
`endif
    end
  end

endmodule
